rtc_burst_seq: RTL and testbench

RTC_BURST_SEQ -- requirements
Module: rtc_burst_seq

---
 rtl/rtc_burst_seq.sv | 198 +++++++++++++++++++
 tb/tb_rtc_burst_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_burst_seq.sv
// RTC register burst sequencer: walks the enabled register slots and drives
// the multiplexed address/data RTC bus through ADDR, GAP1, DATA and GAP2 phases.
module rtc_burst_seq #(
  parameter int unsigned NUM_REGS  = 10,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned PHASE_CYC = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [NUM_REGS-1:0] slot_en,
  input  logic                abort,
  output logic                a_d,
  output logic                cs,
  output logic                rd,
  output logic                wr,
  output logic                bus_oe,
  output logic                capture,
  output logic [NUM_REGS-1:0] addr_stb,
  output logic [NUM_REGS-1:0] dat_stb,
  output logic [IDX_W-1:0]    slot_idx,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam int unsigned CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP1,
    S_DATA,
    S_GAP2,
    S_FIN
  } state_t;

  state_t              state, nxt_state;
  logic [CNT_W-1:0]    cnt, nxt_cnt;
  logic [IDX_W-1:0]    slot, nxt_slot;
  logic                mode_q, nxt_mode;
  logic [NUM_REGS-1:0] mask_q, nxt_mask;
  logic                abort_hit;
  logic [IDX_W:0]      first_slot;
  logic [IDX_W:0]      next_slot;
  logic [NUM_REGS-1:0] slot_oh;

  // Lowest enabled slot at or above 'from'; MSB of the result flags a hit.
  function automatic logic [IDX_W:0] find_slot(input logic [NUM_REGS-1:0] m,
                                               input int from);
    logic [IDX_W:0]      r;
    logic [NUM_REGS-1:0] sh;
    r = '0;
    for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
      sh = m >> i;
      if (i >= from && sh[0]) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  assign first_slot = find_slot(slot_en, 0);
  assign next_slot  = find_slot(mask_q, int'(slot) + 1);
  assign slot_oh    = NUM_REGS'(1) << nxt_slot;

  // Next-state logic; outputs are decoded from the next state and registered.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_slot  = slot;
    nxt_mode  = mode_q;
    nxt_mask  = mask_q;
    abort_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_mode = mode;
          nxt_mask = slot_en;
          nxt_cnt  = '0;
          if (first_slot[IDX_W]) begin
            nxt_state = S_ADDR;
            nxt_slot  = first_slot[IDX_W-1:0];
          end else begin
            nxt_state = S_FIN;
            nxt_slot  = '0;
          end
        end
      end
      S_ADDR, S_GAP1, S_DATA, S_GAP2: begin
        if (abort) begin
          abort_hit = 1'b1;
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
          nxt_slot  = '0;
        end else if (cnt != CNT_LAST) begin
          nxt_cnt = cnt + CNT_W'(1);
        end else begin
          nxt_cnt = '0;
          case (state)
            S_ADDR: nxt_state = S_GAP1;
            S_GAP1: nxt_state = S_DATA;
            S_DATA: nxt_state = S_GAP2;
            default: begin
              if (next_slot[IDX_W]) begin
                nxt_state = S_ADDR;
                nxt_slot  = next_slot[IDX_W-1:0];
              end else begin
                nxt_state = S_FIN;
                nxt_slot  = '0;
              end
            end
          endcase
        end
      end
      S_FIN: begin
        nxt_state = S_IDLE;
        nxt_slot  = '0;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
        nxt_slot  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      slot     <= '0;
      mode_q   <= 1'b0;
      mask_q   <= '0;
      a_d      <= 1'b1;
      cs       <= 1'b1;
      rd       <= 1'b1;
      wr       <= 1'b1;
      bus_oe   <= 1'b0;
      capture  <= 1'b0;
      addr_stb <= '0;
      dat_stb  <= '0;
      slot_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      slot     <= nxt_slot;
      mode_q   <= nxt_mode;
      mask_q   <= nxt_mask;
      a_d      <= 1'b1;
      cs       <= 1'b1;
      rd       <= 1'b1;
      wr       <= 1'b1;
      bus_oe   <= 1'b0;
      capture  <= 1'b0;
      addr_stb <= '0;
      dat_stb  <= '0;
      slot_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= abort_hit;
      case (nxt_state)
        S_ADDR: begin
          a_d      <= 1'b0;
          cs       <= 1'b0;
          wr       <= 1'b0;
          bus_oe   <= 1'b1;
          addr_stb <= slot_oh;
          slot_idx <= nxt_slot;
          busy     <= 1'b1;
        end
        S_GAP1, S_GAP2: begin
          slot_idx <= nxt_slot;
          busy     <= 1'b1;
        end
        S_DATA: begin
          cs       <= 1'b0;
          dat_stb  <= slot_oh;
          slot_idx <= nxt_slot;
          busy     <= 1'b1;
          if (nxt_mode) begin
            wr     <= 1'b0;
            bus_oe <= 1'b1;
          end else begin
            rd      <= 1'b0;
            capture <= (nxt_cnt == CNT_LAST);
          end
        end
        S_FIN: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_burst_seq.sv
// Directed bench for rtc_burst_seq: per-cycle output traces of whole bursts
// compared against hand-computed vector tables and aggregate pulse counts.
module tb_rtc_burst_seq;

  localparam int unsigned NR = 10;
  localparam int unsigned IW = 4;
  localparam int unsigned PC = 4;

  logic          clk = 1'b0;
  logic          reset, start, mode, abort;
  logic [NR-1:0] slot_en;
  logic          a_d, cs, rd, wr, bus_oe, capture, busy, done, aborted;
  logic [NR-1:0] addr_stb, dat_stb;
  logic [IW-1:0] slot_idx;

  always #5 clk = ~clk;

  rtc_burst_seq #(.NUM_REGS(NR), .IDX_W(IW), .PHASE_CYC(PC)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .slot_en(slot_en),
    .abort(abort), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .bus_oe(bus_oe),
    .capture(capture), .addr_stb(addr_stb), .dat_stb(dat_stb),
    .slot_idx(slot_idx), .busy(busy), .done(done), .aborted(aborted)
  );

  typedef struct packed {
    logic a_d, cs, rd, wr, oe, cap, busy, done, abt;
    logic [NR-1:0] astb, dstb;
    logic [IW-1:0] idx;
  } out_t;

  typedef struct {
    int   tid;
    int   cyc;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  out_t tr[0:199];
  int   checks = 0;
  int   errors = 0;

  function automatic out_t sample();
    out_t o;
    o.a_d = a_d; o.cs = cs; o.rd = rd; o.wr = wr; o.oe = bus_oe;
    o.cap = capture; o.busy = busy; o.done = done; o.abt = aborted;
    o.astb = addr_stb; o.dstb = dat_stb; o.idx = slot_idx;
    return o;
  endfunction

  function automatic out_t idle_o();
    out_t o;
    o = '0;
    o.a_d = 1'b1; o.cs = 1'b1; o.rd = 1'b1; o.wr = 1'b1;
    return o;
  endfunction

  function automatic out_t addr_o(input int s);
    out_t o;
    o = idle_o();
    o.a_d = 1'b0; o.cs = 1'b0; o.wr = 1'b0; o.oe = 1'b1; o.busy = 1'b1;
    o.astb = NR'(1) << s; o.idx = IW'(s);
    return o;
  endfunction

  function automatic out_t gap_o(input int s);
    out_t o;
    o = idle_o();
    o.busy = 1'b1; o.idx = IW'(s);
    return o;
  endfunction

  function automatic out_t data_o(input int s, input logic w, input logic c);
    out_t o;
    o = idle_o();
    o.cs = 1'b0; o.busy = 1'b1; o.idx = IW'(s); o.dstb = NR'(1) << s;
    if (w) begin
      o.wr = 1'b0; o.oe = 1'b1;
    end else begin
      o.rd = 1'b0; o.cap = c;
    end
    return o;
  endfunction

  function automatic out_t fin_o();
    out_t o;
    o = idle_o();
    o.done = 1'b1;
    return o;
  endfunction

  function automatic out_t abt_o();
    out_t o;
    o = idle_o();
    o.abt = 1'b1;
    return o;
  endfunction

  function automatic void add(input int tid, input int cyc, input out_t e);
    vecs.push_back('{tid, cyc, e});
  endfunction

  task automatic check_o(input string nm, input int cyc, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  task automatic check_i(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Cycle 0 carries start; inputs for cycle c are set right after sampling it.
  task automatic run_burst(input logic m, input logic [NR-1:0] en, input int n,
                           input int abort_c, input int start_c, input int start_c2,
                           input int reset_c);
    mode = m; slot_en = en; start = 1'b1; abort = 1'b0; reset = 1'b0;
    for (int c = 1; c <= n; c++) begin
      tick();
      tr[c] = sample();
      start = (c == start_c) || (c == start_c2);
      abort = (c == abort_c);
      reset = (c == reset_c);
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  task automatic apply_vecs(input int tid, input string nm);
    foreach (vecs[k])
      if (vecs[k].tid == tid) check_o(nm, vecs[k].cyc, tr[vecs[k].cyc], vecs[k].exp);
  endtask

  task automatic scan(input int lo, input int hi, output int ncap, output int ndone,
                      output int ncs, output int nabt);
    ncap = 0; ndone = 0; ncs = 0; nabt = 0;
    for (int c = lo; c <= hi; c++) begin
      if (tr[c].cap)  ncap++;
      if (tr[c].done) ndone++;
      if (!tr[c].cs)  ncs++;
      if (tr[c].abt)  nabt++;
    end
  endtask

  initial begin
    int ncap, ndone, ncs, nabt, bad;
    logic exp_cap, exp_csl;

    // Test 1: full read burst, stray starts in cycles 50 and 161
    add(1, 1, addr_o(0));   add(1, 4, addr_o(0));   add(1, 5, gap_o(0));
    add(1, 8, gap_o(0));    add(1, 9, data_o(0, 1'b0, 1'b0));
    add(1, 11, data_o(0, 1'b0, 1'b0));  add(1, 12, data_o(0, 1'b0, 1'b1));
    add(1, 13, gap_o(0));   add(1, 16, gap_o(0));   add(1, 17, addr_o(1));
    add(1, 28, data_o(1, 1'b0, 1'b1));  add(1, 50, addr_o(3));
    add(1, 145, addr_o(9)); add(1, 156, data_o(9, 1'b0, 1'b1));
    add(1, 160, gap_o(9));  add(1, 161, fin_o());   add(1, 162, idle_o());
    // Test 2: write burst on slots 0 and 2
    add(2, 1, addr_o(0));   add(2, 4, addr_o(0));   add(2, 5, gap_o(0));
    add(2, 9, data_o(0, 1'b1, 1'b0));   add(2, 12, data_o(0, 1'b1, 1'b0));
    add(2, 13, gap_o(0));   add(2, 16, gap_o(0));   add(2, 17, addr_o(2));
    add(2, 20, addr_o(2));  add(2, 21, gap_o(2));
    add(2, 25, data_o(2, 1'b1, 1'b0));  add(2, 28, data_o(2, 1'b1, 1'b0));
    add(2, 32, gap_o(2));   add(2, 33, fin_o());    add(2, 34, idle_o());
    // Test 3: empty mask
    add(3, 1, fin_o());     add(3, 2, idle_o());
    // Test 4: abort in cycle 20, restart in cycle 21
    add(4, 20, addr_o(1));  add(4, 21, abt_o());    add(4, 22, addr_o(0));
    add(4, 23, addr_o(0));
    // Test 5: abort in the cycle before capture
    add(5, 11, data_o(0, 1'b0, 1'b0));  add(5, 12, abt_o());  add(5, 13, idle_o());
    // Test 6: reset mid-burst
    add(6, 30, gap_o(1));   add(6, 31, idle_o());   add(6, 32, idle_o());
    // Test 7: full burst after reset
    add(7, 1, addr_o(0));   add(7, 12, data_o(0, 1'b0, 1'b1));
    add(7, 161, fin_o());

    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; slot_en = '0;
    tick(); tick();
    check_o("reset_idle", 0, sample(), idle_o());
    start = 1'b1; abort = 1'b1; slot_en = '1;
    tick();
    check_o("reset_priority", 0, sample(), idle_o());
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    tick();
    check_o("post_reset_idle", 0, sample(), idle_o());

    run_burst(1'b0, 10'h3FF, 165, -1, 50, 161, -1);
    apply_vecs(1, "read_full");
    scan(1, 165, ncap, ndone, ncs, nabt);
    check_i("read_full_captures", ncap, 10);
    check_i("read_full_dones", ndone, 1);
    bad = 0;
    for (int c = 1; c <= 165; c++) begin
      exp_cap = (c >= 12) && (c <= 156) && ((c - 12) % 16 == 0);
      exp_csl = (c <= 160) && (((c - 1) % 16 < 4) || ((c - 1) % 16 >= 8 && (c - 1) % 16 < 12));
      if (tr[c].cap !== exp_cap || tr[c].cs !== !exp_csl || tr[c].busy !== (c <= 160)) bad++;
    end
    check_i("read_full_cycle_pattern", bad, 0);
    do_reset();

    run_burst(1'b1, 10'b0000000101, 40, -1, -1, -1, -1);
    apply_vecs(2, "write_sparse");
    scan(1, 40, ncap, ndone, ncs, nabt);
    check_i("write_captures", ncap, 0);
    check_i("write_cs_low_cycles", ncs, 16);
    check_i("write_dones", ndone, 1);
    do_reset();

    run_burst(1'b0, 10'h000, 6, -1, -1, -1, -1);
    apply_vecs(3, "empty_mask");
    scan(1, 6, ncap, ndone, ncs, nabt);
    check_i("empty_cs_low_cycles", ncs, 0);
    do_reset();

    run_burst(1'b0, 10'h3FF, 30, 20, 21, -1, -1);
    apply_vecs(4, "abort_restart");
    scan(1, 30, ncap, ndone, ncs, nabt);
    check_i("abort_dones", ndone, 0);
    check_i("abort_pulses", nabt, 1);
    do_reset();

    run_burst(1'b0, 10'h3FF, 14, 11, -1, -1, -1);
    apply_vecs(5, "abort_no_capture");
    scan(1, 14, ncap, ndone, ncs, nabt);
    check_i("abort_capture_count", ncap, 0);
    do_reset();

    run_burst(1'b0, 10'h3FF, 40, -1, -1, -1, 30);
    apply_vecs(6, "reset_mid_burst");
    scan(1, 40, ncap, ndone, ncs, nabt);
    check_i("reset_mid_dones", ndone, 0);
    check_i("reset_mid_aborts", nabt, 0);

    run_burst(1'b0, 10'h3FF, 165, -1, -1, -1, -1);
    apply_vecs(7, "read_after_reset");
    scan(1, 165, ncap, ndone, ncs, nabt);
    check_i("read_after_reset_captures", ncap, 10);
    check_i("read_after_reset_dones", ndone, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
